// File: rtl/bpu_tournament_dir.sv
// Tournament direction predictor for the two-slot second-level predictor.
// Local (per-PC history -> pattern table), gshare (PC xor speculative GHR)
// and a per-PC chooser pick the taken/not-taken decision for each slot.
// The speculative GHR is snapshotted per slot and restored from EX on a
// misprediction. All lookups are combinational from registered state.
module bpu_tournament_dir #(
    parameter int IDX_W     = 8,
    parameter int GHR_W     = 8,
    parameter int LHT_IDX_W = 7,
    parameter int LHR_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lk_valid1,
    input  logic             lk_valid2,
    input  logic [31:0]      lk_pc1,
    input  logic [31:0]      lk_pc2,
    output logic             pred_taken1,
    output logic             pred_taken2,
    output logic             pred_local1,
    output logic             pred_local2,
    output logic             pred_global1,
    output logic             pred_global2,
    output logic [GHR_W-1:0] ghr_snap1,
    output logic [GHR_W-1:0] ghr_snap2,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic             ex_mispredict,
    input  logic             ex_pred_local,
    input  logic             ex_pred_global,
    input  logic [GHR_W-1:0] ex_ghr_snap,
    output logic [GHR_W-1:0] ghr_o
);

    localparam int N_G   = 1 << IDX_W;
    localparam int N_LHT = 1 << LHT_IDX_W;
    localparam int N_LP  = 1 << LHR_W;

    // Prediction state
    logic [1:0]       gpht_q    [N_G];
    logic [1:0]       chooser_q [N_G];
    logic [1:0]       lpht_q    [N_LP];
    logic [LHR_W-1:0] lht_q     [N_LHT];
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;

    // 2-bit saturating counter step toward the given direction
    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? c : c + 2'd1;
        else
            return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // gshare index: PC index xor zero-extended history
    function automatic logic [IDX_W-1:0] gs_index(input logic [IDX_W-1:0] pc_idx,
                                                  input logic [GHR_W-1:0] hist);
        logic [IDX_W-1:0] hx;
        hx = '0;
        hx[GHR_W-1:0] = hist;
        return pc_idx ^ hx;
    endfunction

    // ---------------- Slot 1 lookup ----------------
    logic [IDX_W-1:0]     lk_idx1, lk_gs_idx1;
    logic [LHT_IDX_W-1:0] lk_lht_idx1;
    logic [LHR_W-1:0]     lk_lhist1;

    assign lk_idx1      = lk_pc1[IDX_W+1:2];
    assign lk_lht_idx1  = lk_pc1[LHT_IDX_W+1:2];
    assign lk_lhist1    = lht_q[lk_lht_idx1];
    assign ghr_snap1    = ghr_q;
    assign lk_gs_idx1   = gs_index(lk_idx1, ghr_snap1);
    assign pred_local1  = lpht_q[lk_lhist1][1];
    assign pred_global1 = gpht_q[lk_gs_idx1][1];
    assign pred_taken1  = chooser_q[lk_idx1][1] ? pred_global1 : pred_local1;

    // ---------------- Slot 2 lookup ----------------
    // Slot 2 sees the history already extended by slot 1's prediction.
    logic [IDX_W-1:0]     lk_idx2, lk_gs_idx2;
    logic [LHT_IDX_W-1:0] lk_lht_idx2;
    logic [LHR_W-1:0]     lk_lhist2;

    assign lk_idx2      = lk_pc2[IDX_W+1:2];
    assign lk_lht_idx2  = lk_pc2[LHT_IDX_W+1:2];
    assign lk_lhist2    = lht_q[lk_lht_idx2];
    assign ghr_snap2    = lk_valid1 ? {ghr_q[GHR_W-2:0], pred_taken1} : ghr_q;
    assign lk_gs_idx2   = gs_index(lk_idx2, ghr_snap2);
    assign pred_local2  = lpht_q[lk_lhist2][1];
    assign pred_global2 = gpht_q[lk_gs_idx2][1];
    assign pred_taken2  = chooser_q[lk_idx2][1] ? pred_global2 : pred_local2;

    assign ghr_o = ghr_q;

    // ---------------- EX training ----------------
    logic [IDX_W-1:0]     ex_idx, ex_gs_idx;
    logic [LHT_IDX_W-1:0] ex_lht_idx;
    logic [LHR_W-1:0]     ex_lhist;
    logic [1:0]           lpht_wr_d, gpht_wr_d, chooser_wr_d;
    logic                 chooser_upd;

    assign ex_idx       = ex_pc[IDX_W+1:2];
    assign ex_lht_idx   = ex_pc[LHT_IDX_W+1:2];
    assign ex_lhist     = lht_q[ex_lht_idx];
    assign ex_gs_idx    = gs_index(ex_idx, ex_ghr_snap);
    assign lpht_wr_d    = sat_step(lpht_q[ex_lhist], ex_taken);
    assign gpht_wr_d    = sat_step(gpht_q[ex_gs_idx], ex_taken);
    // Chooser only learns when the components disagreed.
    assign chooser_upd  = ex_pred_local != ex_pred_global;
    assign chooser_wr_d = sat_step(chooser_q[ex_idx], ex_pred_global == ex_taken);

    // Address bits that do not take part in any index
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lk_pc1[31:IDX_W+2], lk_pc1[1:0],
                              lk_pc2[31:IDX_W+2], lk_pc2[1:0],
                              ex_pc[31:IDX_W+2],  ex_pc[1:0]};

    // Next GHR: EX recovery wins over speculative shifts from this cycle's lookups
    always_comb begin
        ghr_d = ghr_q;
        if (ex_valid && ex_mispredict)
            ghr_d = {ex_ghr_snap[GHR_W-2:0], ex_taken};
        else if (lk_valid2)
            ghr_d = {ghr_snap2[GHR_W-2:0], pred_taken2};
        else
            ghr_d = ghr_snap2;
    end

    // Speculative global history register
    always_ff @(posedge clk) begin
        if (!rst)
            ghr_q <= '0;
        else
            ghr_q <= ghr_d;
    end

    // gshare pattern table, trained at the history the branch was issued with
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_G; i++) gpht_q[i] <= 2'b01;
        end else if (ex_valid) begin
            gpht_q[ex_gs_idx] <= gpht_wr_d;
        end
    end

    // Chooser counters: MSB set selects the global component
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_G; i++) chooser_q[i] <= 2'b01;
        end else if (ex_valid && chooser_upd) begin
            chooser_q[ex_idx] <= chooser_wr_d;
        end
    end

    // Local pattern table, indexed by the pre-update local history
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_LP; i++) lpht_q[i] <= 2'b01;
        end else if (ex_valid) begin
            lpht_q[ex_lhist] <= lpht_wr_d;
        end
    end

    // Local history table: shift in the resolved outcome
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_LHT; i++) lht_q[i] <= '0;
        end else if (ex_valid) begin
            lht_q[ex_lht_idx] <= {ex_lhist[LHR_W-2:0], ex_taken};
        end
    end

endmodule
